// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the block-RAM burst controller.
//   state_t   : controller FSM states
//   RAM_DW/AW : word and address width of the attached single-port RAM
//   CMD_*     : encoding of the cmd_rw command bit
package ram_ctrl_pkg;
    localparam int   RAM_DW    = 8;
    localparam int   RAM_AW    = 8;
    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO that collects RAM read words and presents them to the
// read stream.
//   clk, rst  : clock, asynchronous active-high reset
//   push, din : store din at the tail
//   pop       : drop the head entry (caller guarantees count != 0)
//   head      : current head entry (zero after reset)
//   count     : number of stored entries, 0..2
module rd_skid_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);
    logic [1:0][DW-1:0] mem;
    logic               rptr;
    logic               wptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem   <= '0;
            rptr  <= 1'b0;
            wptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rptr];
endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst access engine in front of a single-port block RAM (1-cycle read
// latency). One command at a time: start address, length-1, direction.
//   CLK, RST                     : clock, asynchronous active-high reset
//   cmd_valid/ready/rw/addr/len  : command handshake (len = words - 1)
//   wr_data/valid/ready          : write stream into the RAM
//   rd_data/valid/ready          : read stream out of the RAM
//   busy, done                   : activity flag, one-cycle completion pulse
//   ram_en/we/addr/din, ram_dout : RAM pins
module ram_burst_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DW = RAM_DW,
    parameter int AW = RAM_AW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_rw,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          busy,
    output logic          done,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    state_t        state;
    logic [AW-1:0] cur;
    logic [AW-1:0] rem;
    logic          inflight;   // a read was issued last cycle; ram_dout is valid now
    logic [1:0]    count;
    logic [1:0]    occ_next;
    logic          wr_beat;
    logic          issue;
    logic          pop;

    // Everything below is derived from registered state, so RST forces the
    // RAM pins and stream handshakes low without waiting for a clock edge.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign wr_ready  = (state == WRITE);
    assign wr_beat   = wr_ready & wr_valid;
    assign rd_valid  = (count != 2'd0);
    assign pop       = rd_valid & rd_ready;

    // Buffer occupancy after this edge: the landing word enters, a popped
    // word leaves. Issuing only while that stays below 2 guarantees room for
    // every in-flight word and still allows one issue per cycle when the
    // consumer drains one word per cycle.
    assign occ_next = count + {1'b0, inflight} - {1'b0, pop};
    assign issue    = (state == READ) && (occ_next < 2'd2);

    assign ram_en   = wr_beat | issue;
    assign ram_we   = wr_beat;
    assign ram_addr = cur;
    assign ram_din  = wr_ready ? wr_data : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cur      <= '0;
            rem      <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            case (state)
                IDLE: if (cmd_valid) begin
                    cur   <= cmd_addr;
                    rem   <= cmd_len;
                    state <= (cmd_rw == CMD_WRITE) ? WRITE : READ;
                end
                WRITE: if (wr_beat) begin
                    cur <= cur + 1'b1;
                    rem <= rem - 1'b1;
                    if (rem == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                READ: if (issue) begin
                    cur <= cur + 1'b1;
                    rem <= rem - 1'b1;
                    if (rem == '0)
                        state <= DRAIN;
                end
                DRAIN: if (!inflight && count == 2'd0) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    rd_skid_buf #(.DW(DW)) u_rd_buf (
        .clk   (CLK),
        .rst   (RST),
        .push  (inflight),
        .pop   (pop),
        .din   (ram_dout),
        .head  (rd_data),
        .count (count)
    );
endmodule
